// File: rtl/gravador_musica.sv
// Melody recorder: turns key presses, releases and metronome beats into (nota, tempo)
// entries for the music RAM and closes every take with a (0,0) terminator.
module gravador_musica #(
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned NOTA_WIDTH  = 4,
  parameter int unsigned TEMPO_WIDTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   inicia,
  input  logic                   para,
  input  logic [NOTA_WIDTH-1:0]  botoes_encoded,
  input  logic                   metro,
  output logic                   we,
  output logic [ADDR_WIDTH-1:0]  addr,
  output logic [NOTA_WIDTH-1:0]  data_nota,
  output logic [TEMPO_WIDTH-1:0] data_tempo,
  output logic                   gravando,
  output logic [ADDR_WIDTH-1:0]  num_notas,
  output logic                   fim_memoria,
  output logic                   pronto
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StEspera = 3'd1;
  localparam logic [2:0] StNota   = 3'd2;
  localparam logic [2:0] StPausa  = 3'd3;
  localparam logic [2:0] StGrava  = 3'd4;
  localparam logic [2:0] StTerm   = 3'd5;
  localparam logic [2:0] StFim    = 3'd6;

  localparam logic [ADDR_WIDTH-1:0]  LastAddr = {ADDR_WIDTH{1'b1}};
  localparam logic [TEMPO_WIDTH-1:0] TempoMax = {TEMPO_WIDTH{1'b1}};
  localparam logic [TEMPO_WIDTH-1:0] TempoOne = {{(TEMPO_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [NOTA_WIDTH-1:0]  NotaRest = '0;

  logic [2:0]             state_q, state_d;
  logic [2:0]             nxt_q, nxt_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]  num_notas_q, num_notas_d;
  logic                   fim_memoria_q, fim_memoria_d;
  logic [TEMPO_WIDTH-1:0] cnt_q, cnt_d;
  logic [NOTA_WIDTH-1:0]  nota_q, nota_d;
  logic [NOTA_WIDTH-1:0]  data_nota_q, data_nota_d;
  logic [TEMPO_WIDTH-1:0] data_tempo_q, data_tempo_d;

  logic [TEMPO_WIDTH-1:0] cnt_inc;
  logic [TEMPO_WIDTH-1:0] tempo_nota;

  // A beat arriving together with a closing edge belongs to the event being closed.
  always_comb begin
    cnt_inc    = (metro && (cnt_q != TempoMax)) ? cnt_q + TempoOne : cnt_q;
    tempo_nota = (cnt_inc == '0) ? TempoOne : cnt_inc;
  end

  always_comb begin
    state_d       = state_q;
    nxt_d         = nxt_q;
    addr_d        = addr_q;
    num_notas_d   = num_notas_q;
    fim_memoria_d = fim_memoria_q;
    cnt_d         = cnt_q;
    nota_d        = nota_q;
    data_nota_d   = data_nota_q;
    data_tempo_d  = data_tempo_q;

    case (state_q)
      StIdle: begin
        if (inicia) begin
          addr_d        = '0;
          num_notas_d   = '0;
          fim_memoria_d = 1'b0;
          cnt_d         = '0;
          state_d       = StEspera;
        end
      end
      StEspera: begin
        if (para) begin
          state_d = StTerm;
        end else if (botoes_encoded != NotaRest) begin
          nota_d  = botoes_encoded;
          cnt_d   = '0;
          state_d = StNota;
        end
      end
      StNota: begin
        if (para || (botoes_encoded != nota_q)) begin
          data_nota_d  = nota_q;
          data_tempo_d = tempo_nota;
          cnt_d        = '0;
          state_d      = StGrava;
          if (para) begin
            nxt_d = StTerm;
          end else if (botoes_encoded == NotaRest) begin
            nxt_d = StPausa;
          end else begin
            nxt_d  = StNota;
            nota_d = botoes_encoded;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StPausa: begin
        if (para) begin
          state_d = StTerm;
        end else if (botoes_encoded != NotaRest) begin
          nota_d = botoes_encoded;
          cnt_d  = '0;
          if (cnt_inc != '0) begin
            data_nota_d  = NotaRest;
            data_tempo_d = cnt_inc;
            nxt_d        = StNota;
            state_d      = StGrava;
          end else begin
            state_d = StNota;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StGrava: begin
        addr_d      = addr_q + 1'b1;
        num_notas_d = num_notas_q + 1'b1;
        // Last slot is reserved for the terminator.
        if (addr_q == LastAddr - 1'b1) begin
          fim_memoria_d = 1'b1;
          state_d       = StTerm;
        end else begin
          state_d = nxt_q;
        end
      end
      StTerm:  state_d = StFim;
      StFim:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (state_d == StTerm) begin
      data_nota_d  = '0;
      data_tempo_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      nxt_q         <= StIdle;
      addr_q        <= '0;
      num_notas_q   <= '0;
      fim_memoria_q <= 1'b0;
      cnt_q         <= '0;
      nota_q        <= '0;
      data_nota_q   <= '0;
      data_tempo_q  <= '0;
    end else begin
      state_q       <= state_d;
      nxt_q         <= nxt_d;
      addr_q        <= addr_d;
      num_notas_q   <= num_notas_d;
      fim_memoria_q <= fim_memoria_d;
      cnt_q         <= cnt_d;
      nota_q        <= nota_d;
      data_nota_q   <= data_nota_d;
      data_tempo_q  <= data_tempo_d;
    end
  end

  always_comb begin
    we          = (state_q == StGrava) || (state_q == StTerm);
    pronto      = (state_q == StFim);
    gravando    = (state_q != StIdle) && (state_q != StFim);
    addr        = addr_q;
    num_notas   = num_notas_q;
    fim_memoria = fim_memoria_q;
    data_nota   = data_nota_q;
    data_tempo  = data_tempo_q;
  end

endmodule

// File: tb/tb_gravador_musica.sv
// Directed bench: expected RAM writes go into a scoreboard queue as stimulus is driven and
// are popped and compared whenever the recorder pulses we.
module tb_gravador_musica;

  logic       clock;
  logic       reset;
  logic       inicia;
  logic       para;
  logic [3:0] botoes_encoded;
  logic       metro;
  logic       we;
  logic [4:0] addr;
  logic [3:0] data_nota;
  logic [3:0] data_tempo;
  logic       gravando;
  logic [4:0] num_notas;
  logic       fim_memoria;
  logic       pronto;

  typedef struct packed {
    logic [4:0] a;
    logic [3:0] n;
    logic [3:0] t;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;

  gravador_musica #(
    .ADDR_WIDTH (5),
    .NOTA_WIDTH (4),
    .TEMPO_WIDTH(4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .inicia        (inicia),
    .para          (para),
    .botoes_encoded(botoes_encoded),
    .metro         (metro),
    .we            (we),
    .addr          (addr),
    .data_nota     (data_nota),
    .data_tempo    (data_tempo),
    .gravando      (gravando),
    .num_notas     (num_notas),
    .fim_memoria   (fim_memoria),
    .pronto        (pronto)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int a, input int n, input int t);
    wr_t e;
    e.a = 5'(a);
    e.n = 4'(n);
    e.t = 4'(t);
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic beat();
    metro = 1'b1;
    tick();
    metro = 1'b0;
  endtask

  task automatic start_take();
    inicia = 1'b1;
    tick();
    inicia = 1'b0;
  endtask

  // Waits a bounded number of cycles for the single pronto pulse.
  task automatic wait_pronto(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clock);
      if (pronto === 1'b1) found = 1'b1;
    end
    chk({tag, "_pronto_seen"}, 32'(found), 32'd1);
    chk({tag, "_gravando_at_fim"}, 32'(gravando), 32'd0);
    @(negedge clock);
    chk({tag, "_pronto_one_cycle"}, 32'(pronto), 32'd0);
    chk({tag, "_gravando_after"}, 32'(gravando), 32'd0);
    chk({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clock) begin
    if (reset === 1'b1 && we === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_we: observed addr=%0d nota=%0d tempo=%0d expected no write",
               addr, data_nota, data_tempo);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", 32'(addr), 32'(e.a));
        chk("wr_nota", 32'(data_nota), 32'(e.n));
        chk("wr_tempo", 32'(data_tempo), 32'(e.t));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset          = 1'b0;
    inicia         = 1'b0;
    para           = 1'b0;
    botoes_encoded = 4'd0;
    metro          = 1'b0;
    #12;
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_gravando", 32'(gravando), 32'd0);
    chk("rst_pronto", 32'(pronto), 32'd0);
    chk("rst_fim", 32'(fim_memoria), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_num", 32'(num_notas), 32'd0);
    reset = 1'b1;
    tick();

    // 1: key 5 for 3 beats, leading beat in ESPERA ignored.
    start_take();
    chk("t1_gravando_espera", 32'(gravando), 32'd1);
    beat();
    botoes_encoded = 4'd5;
    tick();
    beat();
    beat();
    beat();
    botoes_encoded = 4'd0;
    push_exp(0, 5, 3);
    tick();
    tick();
    para = 1'b1;
    push_exp(1, 0, 0);
    tick();
    para = 1'b0;
    wait_pronto("t1");
    chk("t1_num", 32'(num_notas), 32'd1);

    // 2: note, rest, zero-beat note, trailing rest dropped.
    start_take();
    botoes_encoded = 4'd2;
    tick();
    beat();
    beat();
    botoes_encoded = 4'd0;
    push_exp(0, 2, 2);
    tick();
    tick();
    beat();
    beat();
    botoes_encoded = 4'd7;
    push_exp(1, 0, 2);
    tick();
    tick();
    botoes_encoded = 4'd0;
    push_exp(2, 7, 1);
    tick();
    tick();
    beat();
    para = 1'b1;
    push_exp(3, 0, 0);
    tick();
    para = 1'b0;
    wait_pronto("t2");
    chk("t2_num", 32'(num_notas), 32'd3);

    // 3: saturation, direct key change, inicia ignored mid-take.
    start_take();
    botoes_encoded = 4'd3;
    tick();
    inicia = 1'b1;
    for (int i = 0; i < 20; i++) beat();
    inicia = 1'b0;
    botoes_encoded = 4'd4;
    push_exp(0, 3, 15);
    tick();
    tick();
    beat();
    para = 1'b1;
    push_exp(1, 4, 1);
    push_exp(2, 0, 0);
    tick();
    para = 1'b0;
    botoes_encoded = 4'd0;
    wait_pronto("t3");
    chk("t3_num", 32'(num_notas), 32'd2);

    // 4: fill memory, auto-close at slot 31.
    start_take();
    for (int i = 0; i < 31; i++) begin
      botoes_encoded = 4'((i % 15) + 1);
      tick();
      beat();
      push_exp(i, (i % 15) + 1, 1);
      botoes_encoded = 4'd0;
      tick();
      tick();
    end
    push_exp(31, 0, 0);
    wait_pronto("t4");
    chk("t4_fim", 32'(fim_memoria), 32'd1);
    chk("t4_num", 32'(num_notas), 32'd31);
    botoes_encoded = 4'd9;
    tick();
    beat();
    botoes_encoded = 4'd0;
    tick();
    tick();
    chk("t4_fim_held", 32'(fim_memoria), 32'd1);
    chk("t4_addr_held", 32'(addr), 32'd31);

    // 5: asynchronous reset mid-note.
    start_take();
    chk("t5_fim_cleared", 32'(fim_memoria), 32'd0);
    botoes_encoded = 4'd6;
    tick();
    beat();
    beat();
    #2;
    reset = 1'b0;
    #1;
    chk("t5_we", 32'(we), 32'd0);
    chk("t5_gravando", 32'(gravando), 32'd0);
    chk("t5_addr", 32'(addr), 32'd0);
    chk("t5_nota", 32'(data_nota), 32'd0);
    beat();
    botoes_encoded = 4'd0;
    tick();
    reset = 1'b1;
    tick();
    tick();
    chk("t5_idle_after_rst", 32'(gravando), 32'd0);
    start_take();
    botoes_encoded = 4'd9;
    tick();
    beat();
    botoes_encoded = 4'd0;
    push_exp(0, 9, 1);
    tick();
    tick();
    para = 1'b1;
    push_exp(1, 0, 0);
    tick();
    para = 1'b0;
    wait_pronto("t5");

    // 6: para, release and metro in the same cycle.
    start_take();
    botoes_encoded = 4'd6;
    tick();
    beat();
    metro          = 1'b1;
    para           = 1'b1;
    botoes_encoded = 4'd0;
    push_exp(0, 6, 2);
    push_exp(1, 0, 0);
    tick();
    metro = 1'b0;
    para  = 1'b0;
    @(negedge clock);
    chk("t6_we_note", 32'(we), 32'd1);
    chk("t6_addr_note", 32'(addr), 32'd0);
    @(negedge clock);
    chk("t6_we_term", 32'(we), 32'd1);
    chk("t6_addr_term", 32'(addr), 32'd1);
    @(negedge clock);
    chk("t6_pronto", 32'(pronto), 32'd1);
    @(negedge clock);
    chk("t6_pronto_off", 32'(pronto), 32'd0);
    chk("t6_num", 32'(num_notas), 32'd1);
    chk("t6_sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
